// File: rtl/nmi_arb_pkg.sv
// Shared types and constants for the two-master NMI arbiter.
package nmi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_CPU = 2'd1,
        ST_BUSY_DMA = 2'd2
    } nmi_arb_state_e;

    // One-hot owner encoding, also used for the last-grant register
    localparam logic [1:0] OWN_CPU = 2'b01;
    localparam logic [1:0] OWN_DMA = 2'b10;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/nmi_if.sv
// Native memory interface: request (valid/addr/wdata/wstrb) and response (ready/rdata).
interface nmi_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/nmi_arb2.sv
// Round-robin CPU/DMA arbiter onto one NMI slave, grant held per transaction,
// with a bus-timeout that completes hung transfers with ERR_RDATA.
module nmi_arb2
    import nmi_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    nmi_if.slave       cpu_nmi,
    nmi_if.slave       dma_nmi,
    nmi_if.master      nmi,
    output logic [1:0] owner_o,
    output logic       timeout_o
);

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CNT_W   = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    nmi_arb_state_e   r_state;
    nmi_arb_state_e   w_next;
    logic [1:0]       r_last_grant;
    logic [CNT_W-1:0] r_to_cnt;

    logic        w_busy;
    logic        w_own_dma;
    logic        w_own_valid;
    logic        w_to_hit;
    logic        w_nmi_valid;
    logic [31:0] w_nmi_addr;
    logic [31:0] w_nmi_wdata;
    logic [3:0]  w_nmi_wstrb;
    logic        w_own_ready;
    logic [31:0] w_own_rdata;
    logic        w_timeout;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_own_dma   = (r_state == ST_BUSY_DMA);
    assign w_own_valid = w_own_dma ? dma_nmi.valid : cpu_nmi.valid;
    // A slave ready in the last allowed cycle wins over the timeout
    assign w_to_hit    = TO_EN && w_busy && w_own_valid && !nmi.ready && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_last_grant <= OWN_DMA;
        end else begin
            r_state <= w_next;
            if (w_busy && (w_next == ST_IDLE)) begin
                r_last_grant <= w_own_dma ? OWN_DMA : OWN_CPU;
            end
        end
    end

    // IDLE always separates two BUSY periods, so clearing in IDLE covers BUSY entry
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !w_busy) begin
            r_to_cnt <= '0;
        end else if (!nmi.ready && (r_to_cnt != '1)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_nmi_valid = 1'b0;
        w_nmi_addr  = '0;
        w_nmi_wdata = '0;
        w_nmi_wstrb = '0;
        w_own_ready = 1'b0;
        w_own_rdata = '0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_nmi.valid && (!dma_nmi.valid || (r_last_grant == OWN_DMA))) begin
                    w_next = ST_BUSY_CPU;
                end else if (dma_nmi.valid) begin
                    w_next = ST_BUSY_DMA;
                end
            end
            ST_BUSY_CPU, ST_BUSY_DMA: begin
                w_nmi_valid = w_own_valid && !w_to_hit;
                w_nmi_addr  = w_own_dma ? dma_nmi.addr  : cpu_nmi.addr;
                w_nmi_wdata = w_own_dma ? dma_nmi.wdata : cpu_nmi.wdata;
                w_nmi_wstrb = w_own_dma ? dma_nmi.wstrb : cpu_nmi.wstrb;
                w_own_ready = nmi.ready || w_to_hit;
                w_own_rdata = w_to_hit ? ERR_RDATA : nmi.rdata;
                w_timeout   = w_to_hit;
                if (!w_own_valid || (w_nmi_valid && nmi.ready) || w_to_hit) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // Reset cuts the bus off in the same cycle rather than one cycle later
        if (!rst_n_i) begin
            w_nmi_valid = 1'b0;
            w_own_ready = 1'b0;
            w_own_rdata = '0;
            w_timeout   = 1'b0;
        end
    end

    assign nmi.valid = w_nmi_valid;
    assign nmi.addr  = w_nmi_addr;
    assign nmi.wdata = w_nmi_wdata;
    assign nmi.wstrb = w_nmi_wstrb;

    assign cpu_nmi.ready = w_own_ready && !w_own_dma;
    assign cpu_nmi.rdata = w_own_dma ? '0 : w_own_rdata;
    assign dma_nmi.ready = w_own_ready && w_own_dma;
    assign dma_nmi.rdata = w_own_dma ? w_own_rdata : '0;

    assign owner_o   = (r_state == ST_BUSY_CPU) ? OWN_CPU :
                       (r_state == ST_BUSY_DMA) ? OWN_DMA : 2'b00;
    assign timeout_o = w_timeout;

endmodule

// File: tb/tb_nmi_arb2.sv
// Scoreboard bench for nmi_arb2: directed master/slave stimulus, expectations queued ahead.
module tb_nmi_arb2;
    import nmi_arb_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] owner;
    logic       tmo;

    nmi_if cpu_if ();
    nmi_if dma_if ();
    nmi_if dn_if ();

    nmi_arb2 #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hFFFF_FFFF)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .cpu_nmi  (cpu_if),
        .dma_nmi  (dma_if),
        .nmi      (dn_if),
        .owner_o  (owner),
        .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_dma;
        logic [31:0] rdata;
        logic        to;
        int          cyc;
    } rsp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dn_t;

    rsp_t exp_rsp[$];
    dn_t  exp_dn[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    task automatic expire(input string name);
        n_chk++;
        $display("FAIL %s: bound expired, got no event, required one", name);
    endtask

    task automatic push_rsp(input logic d, input logic [31:0] rd, input logic to, input int c);
        rsp_t r;
        r.is_dma = d; r.rdata = rd; r.to = to; r.cyc = c;
        exp_rsp.push_back(r);
    endtask

    task automatic push_dn(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        dn_t d;
        d.addr = a; d.wdata = w; d.wstrb = s;
        exp_dn.push_back(d);
    endtask

    // Slave model: counts BUSY cycles from owner_o, ready on the slv_lat-th one
    int          slv_lat = 1;
    bit          slv_never = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          scnt = 0;
    initial begin
        dn_if.ready = 1'b0;
        dn_if.rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (owner != 2'b00) begin
                scnt++;
                dn_if.ready = !slv_never && (scnt == slv_lat);
                dn_if.rdata = slv_rdata;
            end else begin
                scnt = 0;
                dn_if.ready = 1'b0;
                dn_if.rdata = '0;
            end
        end
    end

    // Monitor: checks every downstream handshake and every master response
    initial begin
        rsp_t r;
        dn_t  d;
        forever begin
            @(negedge clk);
            if (dn_if.valid && dn_if.ready) begin
                if (exp_dn.size() == 0) expire("dn_unexpected");
                else begin
                    d = exp_dn.pop_front();
                    chk("dn_addr", dn_if.addr, d.addr);
                    chk("dn_wdata", dn_if.wdata, d.wdata);
                    chk("dn_wstrb", {28'd0, dn_if.wstrb}, {28'd0, d.wstrb});
                end
            end
            if (cpu_if.ready || dma_if.ready) begin
                if (exp_rsp.size() == 0) expire("rsp_unexpected");
                else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_who", {30'd0, dma_if.ready, cpu_if.ready}, r.is_dma ? 32'd2 : 32'd1);
                    chk("rsp_rdata", r.is_dma ? dma_if.rdata : cpu_if.rdata, r.rdata);
                    chk("rsp_other_rdata", r.is_dma ? cpu_if.rdata : dma_if.rdata, 32'd0);
                    chk("rsp_owner", {30'd0, owner}, r.is_dma ? 32'd2 : 32'd1);
                    chk("rsp_timeout", {31'd0, tmo}, {31'd0, r.to});
                    chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                    if (r.to) chk("to_dn_valid", {31'd0, dn_if.valid}, 32'd0);
                end
            end else if (tmo) begin
                expire("timeout_without_ready");
            end
        end
    end

    task automatic drive(input bit d, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        if (d) begin
            dma_if.valid = 1'b1; dma_if.addr = a; dma_if.wdata = w; dma_if.wstrb = s;
        end else begin
            cpu_if.valid = 1'b1; cpu_if.addr = a; cpu_if.wdata = w; cpu_if.wstrb = s;
        end
    endtask

    task automatic wait_rdy(input bit d);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (d ? dma_if.ready : cpu_if.ready) return;
        end
        expire(d ? "dma_wait_ready" : "cpu_wait_ready");
    endtask

    task automatic txn(input bit d, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        @(posedge clk);
        #1;
        drive(d, a, w, s);
        wait_rdy(d);
    endtask

    task automatic drop(input bit d);
        @(posedge clk);
        #1;
        if (d) dma_if.valid = 1'b0;
        else   cpu_if.valid = 1'b0;
    endtask

    task automatic sync_idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        cpu_if.valid = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0; cpu_if.wstrb = '0;
        dma_if.valid = 1'b0; dma_if.addr = '0; dma_if.wdata = '0; dma_if.wstrb = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_owner", {30'd0, owner}, 32'd0);
        chk("reset_timeout", {31'd0, tmo}, 32'd0);
        chk("reset_dn_valid", {31'd0, dn_if.valid}, 32'd0);
        chk("reset_cpu_ready", {31'd0, cpu_if.ready}, 32'd0);
        chk("reset_dma_ready", {31'd0, dma_if.ready}, 32'd0);

        // CPU read, slave answers in BUSY cycle 3
        sync_idle(1);
        base = cyc + 1;
        slv_lat = 3; slv_rdata = 32'h1234_5678;
        push_rsp(1'b0, 32'h1234_5678, 1'b0, base + 3);
        push_dn(32'h0000_0100, 32'h0, 4'h0);
        txn(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        drop(1'b0);

        // DMA partial write
        sync_idle(2);
        base = cyc + 1;
        slv_lat = 2; slv_rdata = 32'h5A5A_0002;
        push_rsp(1'b1, 32'h5A5A_0002, 1'b0, base + 2);
        push_dn(32'h1000_7004, 32'hDEAD_BEEF, 4'b0011);
        txn(1'b1, 32'h1000_7004, 32'hDEAD_BEEF, 4'b0011);
        drop(1'b1);

        // Both masters requesting continuously: strict alternation
        sync_idle(2);
        base = cyc + 1;
        slv_lat = 1; slv_rdata = 32'hA5A5_A5A5;
        push_rsp(1'b0, 32'hA5A5_A5A5, 1'b0, base + 1);
        push_rsp(1'b1, 32'hA5A5_A5A5, 1'b0, base + 3);
        push_rsp(1'b0, 32'hA5A5_A5A5, 1'b0, base + 5);
        push_rsp(1'b1, 32'hA5A5_A5A5, 1'b0, base + 7);
        push_dn(32'h2000_0000, 32'h0000_00C1, 4'hF);
        push_dn(32'h3000_0000, 32'h0000_00D1, 4'hF);
        push_dn(32'h2000_0004, 32'h0000_00C2, 4'hF);
        push_dn(32'h3000_0004, 32'h0000_00D2, 4'hF);
        fork
            begin
                txn(1'b0, 32'h2000_0000, 32'h0000_00C1, 4'hF);
                txn(1'b0, 32'h2000_0004, 32'h0000_00C2, 4'hF);
                drop(1'b0);
            end
            begin
                txn(1'b1, 32'h3000_0000, 32'h0000_00D1, 4'hF);
                txn(1'b1, 32'h3000_0004, 32'h0000_00D2, 4'hF);
                drop(1'b1);
            end
        join

        // Slave never answers: timeout in BUSY cycle 16
        sync_idle(2);
        base = cyc + 1;
        slv_never = 1'b1; slv_rdata = 32'h1111_2222;
        push_rsp(1'b0, 32'hFFFF_FFFF, 1'b1, base + TO);
        txn(1'b0, 32'h0000_0200, 32'h0, 4'h0);
        drop(1'b0);
        @(negedge clk);
        chk("to_next_owner", {30'd0, owner}, 32'd0);
        chk("to_pulse_width", {31'd0, tmo}, 32'd0);
        slv_never = 1'b0;

        // Slave ready in the very last allowed cycle wins over the timeout
        sync_idle(2);
        base = cyc + 1;
        slv_lat = TO; slv_rdata = 32'hCAFE_0016;
        push_rsp(1'b0, 32'hCAFE_0016, 1'b0, base + TO);
        push_dn(32'h0000_0300, 32'h0, 4'h0);
        txn(1'b0, 32'h0000_0300, 32'h0, 4'h0);
        drop(1'b0);

        // Reset during a DMA transfer; last grant was CPU, reset must restore DMA
        sync_idle(2);
        slv_never = 1'b1;
        drive(1'b1, 32'h5000_0000, 32'h0000_0D00, 4'hF);
        sync_idle(3);
        chk("busy_dma_owner", {30'd0, owner}, 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_dn_valid_cut", {31'd0, dn_if.valid}, 32'd0);
        chk("rst_dma_no_ready", {31'd0, dma_if.ready}, 32'd0);
        chk("rst_no_timeout", {31'd0, tmo}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = cyc;
        slv_never = 1'b0; slv_lat = 1; slv_rdata = 32'h0BAD_F00D;
        drive(1'b0, 32'h4000_0000, 32'h0000_0C00, 4'hF);
        push_rsp(1'b0, 32'h0BAD_F00D, 1'b0, base + 1);
        push_rsp(1'b1, 32'h0BAD_F00D, 1'b0, base + 3);
        push_dn(32'h4000_0000, 32'h0000_0C00, 4'hF);
        push_dn(32'h5000_0000, 32'h0000_0D00, 4'hF);
        @(negedge clk);
        chk("post_rst_owner", {30'd0, owner}, 32'd0);
        chk("post_rst_dn_valid", {31'd0, dn_if.valid}, 32'd0);
        chk("post_rst_cpu_ready", {31'd0, cpu_if.ready}, 32'd0);
        chk("post_rst_dma_ready", {31'd0, dma_if.ready}, 32'd0);
        fork
            begin wait_rdy(1'b0); drop(1'b0); end
            begin wait_rdy(1'b1); drop(1'b1); end
        join

        for (int i = 0; i < 100 && (exp_rsp.size() != 0 || exp_dn.size() != 0); i++) @(negedge clk);
        chk("rsp_queue_left", exp_rsp.size(), 32'd0);
        chk("dn_queue_left", exp_dn.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nmi_arb2.md
# nmi_arb2

Two-master, one-slave arbiter on the native memory interface (NMI), placed directly upstream of the native peripheral wrapper's `nmi` slave port. It merges the CPU data port and the DMA engine's `dma_nmi` master port onto a single downstream NMI. Arbitration is round-robin, and each grant is held for the whole transaction. A bus-timeout counter terminates transactions that hang and reports them with a pulse.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum number of BUSY cycles allowed without downstream `ready`. A value of 0 disables the timeout.
- `ERR_RDATA`, default 32'hFFFF_FFFF: `rdata` returned to the master on a timeout.

Ports:
- `clk_i`  input  1: single clock. The whole block runs in this domain.
- `rst_n_i`  input  1: reset, synchronous and active-low.
- `cpu_nmi`  `nmi_if.slave`: CPU request port (valid, addr, wdata, wstrb / ready, rdata).
- `dma_nmi`  `nmi_if.slave`: DMA request port, same signal set.
- `nmi`  `nmi_if.master`: to the peripheral wrapper.
- `owner_o`  output  2: one-hot current owner. Bit 0 = CPU, bit 1 = DMA, 0 when IDLE.
- `timeout_o`  output  1: one-cycle pulse when a transaction is terminated by timeout.

## Operation
- FSM states: IDLE, BUSY_CPU, BUSY_DMA.
- IDLE:
  - Downstream `nmi.valid` = 0.
  - If only one master has `valid` high, go to that master's BUSY state.
  - If both are high, grant the master that was not granted last (`last_grant` register), then go to its BUSY state.
- BUSY_x:
  - `nmi.valid/addr/wdata/wstrb` = owner's signals.
  - Owner's `ready` = `nmi.ready`, owner's `rdata` = `nmi.rdata`.
  - The non-owner sees `ready` = 0 and `rdata` = 0.
- Completion: on a BUSY cycle with `nmi.valid & nmi.ready`, go to IDLE and set `last_grant` = owner.
- Abort: if the owner drops `valid` while in BUSY (protocol violation), go to IDLE next cycle. No ready is returned and `last_grant` is updated.
- Timeout:
  - `to_cnt` is cleared on entering BUSY and increments on each BUSY cycle without `nmi.ready`.
  - If `TIMEOUT_CYCLES` ≠ 0 and `to_cnt == TIMEOUT_CYCLES-1` with no `nmi.ready` in that cycle:
    - Owner `ready` = 1 and owner `rdata` = `ERR_RDATA`.
    - `nmi.valid` is forced to 0 that cycle.
    - `timeout_o` = 1.
    - Go to IDLE and update `last_grant`.
  - If `nmi.ready` arrives in that same cycle, it wins: normal completion, no timeout.
- Counter width: `$clog2(TIMEOUT_CYCLES+1)`, saturating, never wraps.
- Write strobes and addresses are passed unmodified. No address decoding is done in this block.

## Timing
- Reset values:
  - State = IDLE, `last_grant` = DMA (so the CPU wins the first tie), `to_cnt` = 0.
  - `owner_o` = 0, `timeout_o` = 0, `nmi.valid` = 0, both master `ready` = 0.
- Reset mid-transaction: the next cycle is IDLE. The in-flight master gets no ready, and downstream `valid` drops immediately.
- Latency:
  - Request seen in IDLE at cycle N → grant registered, downstream `valid` at N+1.
  - `ready`/`rdata` are combinational pass-through in BUSY (0 added cycles on the return path).
- Back-to-back: after completion at cycle M the FSM is IDLE at M+1 and can grant again, so the next downstream `valid` is at M+2. Each access costs at least 2 cycles plus slave latency.
- Fairness: with both masters continuously requesting, grants strictly alternate (CPU, DMA, CPU, ...).
- `owner_o` is registered, valid from cycle N+1, and cleared in the cycle after completion.

## Structure
- Shared package `nmi_arb_pkg`:
  - FSM state enum `nmi_arb_state_e`.
  - Owner encoding constants (`OWN_CPU`, `OWN_DMA`).
  - Default `ERR_RDATA` constant.
- No sub-module: the round-robin selector is two-way and stays inline. The timeout counter is a local always_ff block.
- The existing `nmi_if` interface is reused for all three bus ports.

## Test plan
- Single CPU read, slave ready after 3 cycles, `rdata`=32'h1234_5678 → CPU sees ready on BUSY cycle 3 with 32'h1234_5678; DMA `ready` stays 0; `owner_o`=01 during BUSY.
- CPU and DMA both assert `valid` at cycle 0 after reset, slave always ready → grants CPU, DMA, CPU, DMA; the 4 transactions complete at cycles 1, 3, 5, 7.
- DMA write, `wstrb`=4'b0011, addr 32'h1000_7004 → downstream sees the identical addr/wdata/wstrb, and the DMA gets ready the same cycle as the slave.
- `TIMEOUT_CYCLES`=16, slave never ready → at BUSY cycle 16: master ready=1 with `rdata`=32'hFFFF_FFFF, `timeout_o` pulses 1 cycle, `nmi.valid`=0, FSM returns to IDLE.
- Slave ready in exactly BUSY cycle 16 with `TIMEOUT_CYCLES`=16 → normal completion with slave data; `timeout_o` stays 0.
- `rst_n_i` low for 1 cycle during a DMA BUSY state → next cycle IDLE with all outputs at reset values; a following simultaneous request is granted to the CPU.
